serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_defs.sv | 16 +
 rtl/bit_slice_fa.sv | 13 +
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_defs.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// bit-counter width derivation used by serial_add_ctrl.
package serial_add_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold values up to WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_slice_fa.sv
// Single combinational 1-bit full adder, time-shared by serial_add_ctrl.
module bit_slice_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, adds one bit per
// clock LSB-first through a single full-adder slice, then publishes
// sum/c_out/ovf with a one-cycle done pulse.
// Optional build macro SERIAL_SUB_EN adds a 'sub' input selecting a-b.
module serial_add_ctrl
    import serial_add_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_IN   = CNT_W'(WIDTH - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             c_msb;
    logic             slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] b_ld;
    logic             cin_ld;

    bit_slice_fa u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Operand B and initial carry as they are loaded on an accepted start.
`ifdef SERIAL_SUB_EN
    always_comb begin
        b_ld   = sub ? ~b : b;
        cin_ld = sub ? 1'b1 : c_in;
    end
`else
    always_comb begin
        b_ld   = b;
        cin_ld = c_in;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake status decode.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a
        // variable unassigned, which would infer a latch.
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand load, per-bit shift/accumulate, result publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_ld;
                        carry <= cin_ld;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_sh <= {slice_s, sum_sh[WIDTH-1:1]};
                    carry  <= slice_c;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt == MSB_IN) c_msb <= slice_c;
                end
                ST_DONE: begin
                    sum   <= sum_sh;
                    c_out <= carry;
                    ovf   <= c_msb ^ carry;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): the stimulus thread pushes
// expected results, a monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        string      name;
        logic [7:0] sum;
        logic       c_out;
        logic       ovf;
        int         acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         busy;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         done;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done at cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_sum"},     32'(sum),         32'(e.sum));
                check({e.name, "_c_out"},   32'(c_out),       32'(e.c_out));
                check({e.name, "_ovf"},     32'(ovf),         32'(e.ovf));
                check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(W + 1));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic issue(input string name, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic sb_sub,
                         input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        wait_ready();
        a    = av;
        b    = bv;
        c_in = ci;
`ifdef SERIAL_SUB_EN
        sub  = sb_sub;
`else
        if (sb_sub) check("sub_unsupported", 32'(sb_sub), 32'd0);
`endif
        start = 1'b1;
        e.name = name; e.sum = es; e.c_out = ec; e.ovf = eo; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sb_sub,
                          input logic [7:0] es, input logic ec, input logic eo);
        issue(name, av, bv, ci, sb_sub, es, ec, eo);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int d1;
        int d2;
        int done_cnt;
        logic hold_ok;
        logic sum_held;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
`ifdef SERIAL_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_sum",   32'(sum),   32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed add vectors.
        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_00", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

        // Start and operand changes while busy are ignored; prior result holds.
        issue("ignore_start", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        n = 0; hold_ok = 1'b1; sum_held = 1'b1;
        while (!done && n < 40) begin
            if (!(busy && !ready)) hold_ok = 1'b0;
            if (sum !== 8'h80) sum_held = 1'b0;
            if (n == 2) begin
                start = 1'b1;
                a     = 8'hF0;
                b     = 8'h0F;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("busy_hold",      32'(hold_ok),  32'd1);
        check("sum_hold_prior", 32'(sum_held), 32'd1);
        @(negedge clk);
        check("ready_after_done", 32'(ready), 32'd1);

        // Synchronous reset mid-RUN aborts without a done pulse.
        wait_ready();
        a = 8'h55; b = 8'h11; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_sum",   32'(sum),   32'd0);
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op("after_abort", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

        // Back-to-back with start held high.
        issue("b2b_first", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        start = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_with_ready", 32'(done), 32'd1);
        d1 = cyc;
        begin
            exp_t e;
            a = 8'h80; b = 8'h80; c_in = 1'b0;
            e.name = "b2b_second"; e.sum = 8'h00; e.c_out = 1'b1; e.ovf = 1'b1; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done();
        d2 = cyc;
        check("b2b_spacing", 32'(d2 - d1), 32'(W + 2));
        @(negedge clk);

`ifdef SERIAL_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
